// File: rtl/rr_arbiter_8way_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
package rr_arbiter_8way_pkg;

  localparam int unsigned NUM_WAYS = 8;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  // Last-served index out of reset; 7 makes line 0 win first.
  localparam logic [IDX_W-1:0] RESET_LAST_IDX = 3'd7;

  function automatic logic [NUM_WAYS-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [NUM_WAYS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_8way_if.sv
// Request/grant bundle between the 8 bus masters and the arbiter.
interface rr_arbiter_8way_if;
  import rr_arbiter_8way_pkg::*;

  logic [NUM_WAYS-1:0] req;
  logic                done;
  logic [NUM_WAYS-1:0] grant;
  logic                grant_valid;
  logic [IDX_W-1:0]    grant_idx;
  logic                any_req;
  logic                timeout;

  // Requester side
  modport master (
    output req, done,
    input  grant, grant_valid, grant_idx, any_req, timeout
  );

  // Arbiter side
  modport slave (
    input  req, done,
    output grant, grant_valid, grant_idx, any_req, timeout
  );

endinterface

// File: rtl/rr_arbiter_8way_pick8.sv
// Combinational round-robin pick: first set request after last_idx, wrapping mod 8.
module rr_pick8
  import rr_arbiter_8way_pkg::*;
(
  input  logic [NUM_WAYS-1:0] req,
  input  logic [IDX_W-1:0]    last_idx,
  output logic [IDX_W-1:0]    pick_idx,
  output logic                pick_valid
);

  logic [IDX_W-1:0]    offset;
  logic [NUM_WAYS-1:0] rot;
  logic [IDX_W-1:0]    prio;

  assign offset = last_idx + IDX_W'(1);

  // Rotate right by offset; 3-bit index arithmetic wraps naturally.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      logic [IDX_W-1:0] src;
      src    = IDX_W'(i) + offset;
      rot[i] = req[src];
    end
  end

  // Fixed priority, lowest rotated position wins.
  always_comb begin
    prio = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (rot[i]) prio = IDX_W'(i);
    end
  end

  assign pick_idx   = prio + offset;
  assign pick_valid = |req;

endmodule

// File: rtl/rr_arbiter_8way.sv
// 8-requester round-robin arbiter with registered one-hot grant and optional hold timeout.
module rr_arbiter_8way
  import rr_arbiter_8way_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned CNT_W    = 8
) (
  input logic              clk,
  input logic              rst_n,
  rr_arbiter_8way_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit               HOLD_EN   = (MAX_HOLD != 0);

  state_e              state_q, state_d;
  logic [NUM_WAYS-1:0] grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic                timeout_q, timeout_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                owner_req;
  logic                hold_hit;
  logic                release_now;

  rr_pick8 u_pick (
    .req        (bus.req),
    .last_idx   (last_q),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign owner_req   = bus.req[idx_q];
  assign hold_hit    = HOLD_EN && (hold_q == HOLD_LAST);
  assign release_now = bus.done || !owner_req || hold_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      last_q    <= RESET_LAST_IDX;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = onehot8(pick_idx);
          valid_d = 1'b1;
          idx_d   = pick_idx;
          last_d  = pick_idx;
          hold_d  = '0;
          state_d = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (release_now) begin
          grant_d   = '0;
          valid_d   = 1'b0;
          state_d   = ST_IDLE;
          // Flag a forced release only when nothing else would have released.
          timeout_d = hold_hit && !bus.done && owner_req;
        end else if (hold_q != '1) begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = idx_q;
  assign bus.timeout     = timeout_q;
  assign bus.any_req     = |bus.req;

endmodule

// File: tb/tb_rr_arbiter_8way.sv
// Directed bench for rr_arbiter_8way: one instance without timeout, one with MAX_HOLD=4.
module tb_rr_arbiter_8way;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  rr_arbiter_8way_if ifa ();
  rr_arbiter_8way_if ifb ();

  rr_arbiter_8way #(.MAX_HOLD(0), .CNT_W(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  rr_arbiter_8way #(.MAX_HOLD(4), .CNT_W(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n    = 1'b0;
    ifa.req  = '0;
    ifa.done = 1'b0;
    ifb.req  = '0;
    ifb.done = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] e;
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    ifa.req  = '0;
    ifa.done = 1'b0;
    ifb.req  = '0;
    ifb.done = 1'b0;
    #1;
    check("rst_grant",   32'(ifa.grant), 32'h0);
    check("rst_valid",   32'(ifa.grant_valid), 32'h0);
    check("rst_idx",     32'(ifa.grant_idx), 32'h0);
    check("rst_timeout", 32'(ifa.timeout), 32'h0);
    check("rst_anyreq",  32'(ifa.any_req), 32'h0);
    check("rst_grant_b", 32'(ifb.grant), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // done while idle does nothing
    ifa.done = 1'b1;
    tick();
    check("idle_done", 32'(ifa.grant_valid), 32'h0);
    ifa.done = 1'b0;

    // single requester, release via done
    ifa.req = 8'h01;
    #1;
    check("anyreq", 32'(ifa.any_req), 32'h1);
    tick();
    check("t1_grant", 32'(ifa.grant), 32'h01);
    check("t1_idx",   32'(ifa.grant_idx), 32'h0);
    check("t1_valid", 32'(ifa.grant_valid), 32'h1);
    ifa.done = 1'b1;
    tick();
    check("t1_rel_grant",   32'(ifa.grant), 32'h0);
    check("t1_rel_valid",   32'(ifa.grant_valid), 32'h0);
    check("t1_rel_timeout", 32'(ifa.timeout), 32'h0);
    ifa.done = 1'b0;
    ifa.req  = '0;
    tick();
    check("t1_idle", 32'(ifa.grant), 32'h0);

    // all requesting: 0..7,0 with one idle cycle between grants
    do_reset();
    ifa.req = 8'hFF;
    tick();
    for (int k = 0; k < 9; k++) begin
      e = 3'(k);
      check("rot_idx",   32'(ifa.grant_idx), 32'(e));
      check("rot_grant", 32'(ifa.grant), 32'(1) << e);
      ifa.done = 1'b1;
      tick();
      check("rot_gap", 32'(ifa.grant_valid), 32'h0);
      ifa.done = 1'b0;
      tick();
    end

    // wrap-around rotation from owner 3
    do_reset();
    ifa.req = 8'h08;
    tick();
    check("wrap_own3", 32'(ifa.grant_idx), 32'h3);
    ifa.req = 8'h89;
    tick();
    check("wrap_hold", 32'(ifa.grant), 32'h08);
    ifa.done = 1'b1;
    tick();
    check("wrap_gap", 32'(ifa.grant_valid), 32'h0);
    ifa.done = 1'b0;
    tick();
    check("wrap_idx7", 32'(ifa.grant_idx), 32'h7);
    ifa.done = 1'b1;
    tick();
    ifa.done = 1'b0;
    tick();
    check("wrap_idx0", 32'(ifa.grant_idx), 32'h0);
    ifa.done = 1'b1;
    tick();
    ifa.done = 1'b0;
    tick();
    check("wrap_idx3", 32'(ifa.grant_idx), 32'h3);

    // hold timeout after 4 granted cycles
    do_reset();
    ifb.req = 8'h04;
    tick();
    check("to_c1", 32'(ifb.grant), 32'h04);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("to_held", 32'(ifb.grant), 32'h04);
      check("to_notyet", 32'(ifb.timeout), 32'h0);
    end
    tick();
    check("to_grant", 32'(ifb.grant), 32'h0);
    check("to_pulse", 32'(ifb.timeout), 32'h1);
    tick();
    check("to_pulse_end", 32'(ifb.timeout), 32'h0);
    check("to_regrant",   32'(ifb.grant), 32'h04);
    check("to_regrant_i", 32'(ifb.grant_idx), 32'h2);

    // done coincides with timeout: done wins
    repeat (3) tick();
    check("co_held", 32'(ifb.grant), 32'h04);
    ifb.done = 1'b1;
    tick();
    check("co_grant",   32'(ifb.grant), 32'h0);
    check("co_timeout", 32'(ifb.timeout), 32'h0);
    ifb.done = 1'b0;
    tick();
    check("drop_regrant", 32'(ifb.grant), 32'h04);
    ifb.req = '0;
    tick();
    check("drop_grant",   32'(ifb.grant), 32'h0);
    check("drop_timeout", 32'(ifb.timeout), 32'h0);

    // async reset mid-grant, then restart from line 0
    do_reset();
    ifa.req = 8'h20;
    tick();
    check("ar_grant", 32'(ifa.grant), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_async_grant", 32'(ifa.grant), 32'h0);
    check("ar_async_valid", 32'(ifa.grant_valid), 32'h0);
    ifa.req = 8'h21;
    #1;
    rst_n = 1'b1;
    tick();
    check("ar_restart_idx",   32'(ifa.grant_idx), 32'h0);
    check("ar_restart_grant", 32'(ifa.grant), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8way.md
Name: rr_arbiter_8way

Overview:
- 8-requester round-robin arbiter: the distributing end of an 8-line request/“any-set” interface. It collapses 8 request lines into one grant.
- Issues a registered one-hot grant and holds it until the owner releases it.
- Optional hold timeout forces release so no single requester can starve the others.
- Sits between 8 bus masters (e.g. CPU, DMA, screen/keyboard controllers) and one shared resource.

Parameters:
- MAX_HOLD, 0, maximum cycles a grant may be held; 0 disables the timeout.
- CNT_W, 8, width of the hold counter; must satisfy MAX_HOLD < 2**CNT_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  request lines, one per master; level-sensitive.
- done  in  1  release pulse from the current owner; ignored when no grant is active.
- grant  out  8  one-hot grant, registered; all zero when idle.
- grant_valid  out  1  equals |grant, registered.
- grant_idx  out  3  binary index of the granted line; holds its last value while idle.
- any_req  out  1  combinational OR of req.
- timeout  out  1  one-cycle registered pulse on the cycle a grant is forcibly released.

Behaviour:
- Reset (async assert, sync deassert by the user): state=IDLE, grant=0, grant_valid=0, grant_idx=0, timeout=0, hold_cnt=0, last_idx=7. The value 7 makes line 0 win the first arbitration.
- States: IDLE, GRANTED.
- IDLE, any_req=0: stay in IDLE, all outputs idle.
- IDLE, any_req=1: pick the first set req bit scanning last_idx+1, last_idx+2, … with wrap-around modulo 8.
  - On the same edge: grant=onehot(pick), grant_idx=pick, last_idx=pick, hold_cnt=0, go to GRANTED.
  - Latency: req sampled high at edge k gives grant visible after edge k (one cycle from req assertion).
- GRANTED, release condition is any of:
  - done=1,
  - req[grant_idx]=0 (the requester dropped),
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- GRANTED, on release: next edge clears grant and grant_valid, then return to IDLE.
  - The timeout bit is set only if the timeout was the sole cause. If done and timeout coincide, done wins and timeout=0.
- GRANTED, otherwise: hold_cnt increments and saturates at 2**CNT_W-1; the grant is unchanged.
- Minimum one IDLE cycle between consecutive grants, even back-to-back to different requesters. Grant-to-grant spacing is therefore ≥2 cycles.
- Simultaneous requests: the winner is strictly determined by rotation from last_idx+1. A released requester has lowest priority next round.
- Changes to req for non-owners during GRANTED have no effect on outputs.
- done in IDLE is ignored.
- Reset mid-grant: grant drops asynchronously on rst_n low, and arbitration restarts from line 0.
- grant is always one-hot or zero; it is never multi-hot.
- timeout is high for exactly one cycle, coincident with the cycle grant goes to zero.

Decomposition:
- Shared package/header: state encodings (ST_IDLE=1'b0, ST_GRANTED=1'b1), RESET_LAST_IDX=3'd7, NUM_WAYS=8.
- One sub-module: rr_pick8, combinational.
  - Inputs: req[7:0], last_idx[2:0].
  - Outputs: pick_idx[2:0], pick_valid.
  - Implementation: rotate req right by last_idx+1, fixed-priority encode, add the offset back modulo 8.
- The top level holds the FSM, hold counter and output registers.

Test Plan:
- Reset, then req=8'b0000_0001 → after 1 edge grant=8'h01, grant_idx=0, grant_valid=1; pulse done → next edge grant=0, timeout=0.
- req=8'hFF held, done pulsed each time a grant is active → grant_idx sequence 0,1,2,…,7,0 with exactly one idle cycle between grants.
- Owner idx 3; req=8'b1000_1001, release → next grant idx 7, then idx 0, then idx 3 (wrap-around rotation).
- MAX_HOLD=4, req=8'h04 held, no done → grant active 4 cycles, then grant=0 with timeout=1 for 1 cycle; regrant to idx 2 after the idle cycle.
- MAX_HOLD=4, done asserted on the same cycle the timeout would fire → grant clears, timeout stays 0. Separately, req[grant_idx] dropped mid-grant → release on the next edge.
- rst_n pulled low while grant=8'h20 → grant=0 immediately (asynchronous); after release with req=8'h21 → grant_idx=0.
